// File: rtl/pkt_buf_ctrl_pkg.sv
// rtl/pkt_buf_ctrl_pkg.sv - shared state encoding and default widths for the packet buffer controller
package pkt_buf_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_PROC = 2'd2,
    ST_SEND = 2'd3
  } state_e;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_CTRL_WIDTH = 8;

endpackage

// File: rtl/pkt_buf_ctrl_rd_pipe.sv
// rtl/pkt_buf_ctrl_rd_pipe.sv - read pointer, issue gating and one-cycle out_wr pipeline for draining
module pkt_buf_ctrl_rd_pipe
  import pkt_buf_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  active,
  input  logic                  out_rdy,
  input  logic [ADDR_WIDTH-1:0] pkt_last,
  output logic [ADDR_WIDTH-1:0] rptr,
  output logic                  out_wr,
  output logic                  done
);

  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic                  last_issued_q, last_issued_d;
  logic                  out_wr_q, out_wr_d;
  logic                  issue;

  // A flag rather than rptr <= pkt_last, so a packet ending at the top address cannot wrap.
  assign issue = active & out_rdy & ~last_issued_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q        <= '0;
      last_issued_q <= 1'b0;
      out_wr_q      <= 1'b0;
    end else begin
      rptr_q        <= rptr_d;
      last_issued_q <= last_issued_d;
      out_wr_q      <= out_wr_d;
    end
  end

  always_comb begin
    rptr_d        = rptr_q;
    last_issued_d = last_issued_q;
    out_wr_d      = issue;
    if (start) begin
      rptr_d        = '0;
      last_issued_d = 1'b0;
    end else if (issue) begin
      rptr_d = rptr_q + ADDR_WIDTH'(1);
      if (rptr_q == pkt_last) last_issued_d = 1'b1;
    end
  end

  assign rptr   = rptr_q;
  assign out_wr = out_wr_q;
  assign done   = active & last_issued_q & out_wr_q;

endmodule

// File: rtl/pkt_buf_ctrl.sv
// rtl/pkt_buf_ctrl.sv - single-packet CPU buffer controller: network fill, CPU handoff, downstream drain
module pkt_buf_ctrl
  import pkt_buf_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CTRL_WIDTH = DEF_CTRL_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_wr,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  in_rdy,
  input  logic                  out_rdy,
  output logic                  out_wr,
  input  logic                  cpu_done,
  input  logic                  cpu_wen,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  cpu_sel,
  output logic [ADDR_WIDTH-1:0] pkt_last,
  output logic                  ovf_err
);

  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] pkt_last_q, pkt_last_d;
  logic                  ovf_err_q, ovf_err_d;
  logic                  cpu_sel_q, cpu_sel_d;
  logic                  full_q, full_d;
  logic                  seen_zero_q, seen_zero_d;

  logic                  net_wen, ctrl_zero, is_eop, at_top;
  logic                  rd_start, rd_done;
  logic [ADDR_WIDTH-1:0] rptr;

  // EOP needs a data word (ctrl == 0) earlier in the packet, so module headers never end it.
  assign ctrl_zero = (in_ctrl == '0);
  assign is_eop    = seen_zero_q & ~ctrl_zero;
  assign at_top    = (wptr_q == TOP_ADDR);
  assign rd_start  = (state_q == ST_PROC) & cpu_done;

  pkt_buf_ctrl_rd_pipe #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .start    (rd_start),
    .active   (state_q == ST_SEND),
    .out_rdy  (out_rdy),
    .pkt_last (pkt_last_q),
    .rptr     (rptr),
    .out_wr   (out_wr),
    .done     (rd_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      pkt_last_q  <= '0;
      ovf_err_q   <= 1'b0;
      cpu_sel_q   <= 1'b0;
      full_q      <= 1'b0;
      seen_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      pkt_last_q  <= pkt_last_d;
      ovf_err_q   <= ovf_err_d;
      cpu_sel_q   <= cpu_sel_d;
      full_q      <= full_d;
      seen_zero_q <= seen_zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    pkt_last_d  = pkt_last_q;
    ovf_err_d   = ovf_err_q;
    full_d      = full_q;
    seen_zero_d = seen_zero_q;
    case (state_q)
      ST_IDLE: begin
        wptr_d      = '0;
        full_d      = 1'b0;
        seen_zero_d = 1'b0;
        if (net_wen) begin
          state_d     = ST_RECV;
          wptr_d      = ADDR_WIDTH'(1);
          seen_zero_d = ctrl_zero;
        end
      end
      ST_RECV: begin
        if (net_wen) begin
          seen_zero_d = seen_zero_q | ctrl_zero;
          if (at_top) full_d = 1'b1;
          else        wptr_d = wptr_q + ADDR_WIDTH'(1);
          if (is_eop || at_top) begin
            state_d    = ST_PROC;
            pkt_last_d = wptr_q;
            if (!is_eop) ovf_err_d = 1'b1;
          end
        end
      end
      ST_PROC: if (cpu_done) state_d = ST_SEND;
      ST_SEND: begin
        if (rd_done) begin
          state_d = ST_IDLE;
          wptr_d  = '0;
          full_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cpu_sel_d = (state_d == ST_PROC);
  end

  always_comb begin
    in_rdy    = ((state_q == ST_IDLE) || (state_q == ST_RECV)) & ~full_q;
    net_wen   = in_wr & in_rdy;
    mem_wen   = cpu_sel_q ? cpu_wen : net_wen;
    mem_waddr = cpu_sel_q ? cpu_addr : wptr_q;
    mem_raddr = (state_q == ST_SEND) ? rptr : cpu_addr;
  end

  assign cpu_sel  = cpu_sel_q;
  assign pkt_last = pkt_last_q;
  assign ovf_err  = ovf_err_q;

endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// tb/tb_pkt_buf_ctrl.sv - scoreboard bench for pkt_buf_ctrl with a behavioural packet memory
module tb_pkt_buf_ctrl;

  localparam int AW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, in_wr, in_rdy, out_rdy, out_wr, cpu_done, cpu_wen;
  logic [CW-1:0] in_ctrl;
  logic [AW-1:0] cpu_addr, mem_waddr, mem_raddr, pkt_last;
  logic          mem_wen, cpu_sel, ovf_err;

  logic          in_wr4, in_rdy4, out_wr4, mem_wen4, cpu_sel4, ovf4;
  logic [3:0]    mem_waddr4, mem_raddr4, pkt_last4;

  logic [15:0]   mem [0:255];
  logic [15:0]   exp_mem [0:255];
  logic [15:0]   in_data, cpu_data, rd_data;
  logic [15:0]   exp_q [$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pkt_buf_ctrl #(.ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_wr(in_wr), .in_ctrl(in_ctrl), .in_rdy(in_rdy),
    .out_rdy(out_rdy), .out_wr(out_wr), .cpu_done(cpu_done), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .cpu_sel(cpu_sel), .pkt_last(pkt_last), .ovf_err(ovf_err)
  );

  pkt_buf_ctrl #(.ADDR_WIDTH(4), .CTRL_WIDTH(CW)) dut4 (
    .clk(clk), .reset(reset), .in_wr(in_wr4), .in_ctrl(in_ctrl), .in_rdy(in_rdy4),
    .out_rdy(1'b0), .out_wr(out_wr4), .cpu_done(1'b0), .cpu_wen(1'b0),
    .cpu_addr(4'd0), .mem_wen(mem_wen4), .mem_waddr(mem_waddr4), .mem_raddr(mem_raddr4),
    .cpu_sel(cpu_sel4), .pkt_last(pkt_last4), .ovf_err(ovf4)
  );

  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= cpu_sel ? cpu_data : in_data;
    rd_data <= mem[mem_raddr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    vectors++; if (in_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
    vectors++; if (cpu_sel !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_sel: got %b want 0", cpu_sel); end
    vectors++; if (out_wr !== 1'b0) begin miscompares++; $display("FAIL reset_out_wr: got %b want 0", out_wr); end
    vectors++; if (ovf_err !== 1'b0) begin miscompares++; $display("FAIL reset_ovf_err: got %b want 0", ovf_err); end
    vectors++; if (pkt_last !== 8'd0) begin miscompares++; $display("FAIL reset_pkt_last: got %0d want 0", pkt_last); end
    vectors++; if (in_rdy4 !== 1'b1) begin miscompares++; $display("FAIL reset_in_rdy4: got %b want 1", in_rdy4); end
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    vectors++; if ({cpu_sel, in_rdy} !== 2'b01) begin miscompares++; $display("FAIL idle_cpu_done_ignored: got sel/rdy %b want 01", {cpu_sel, in_rdy}); end
  endtask

  task automatic test_packet;
    logic [7:0] ctrls [4] = '{8'hFF, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 4; i++) begin
      in_wr = 1'b1; in_ctrl = ctrls[i]; in_data = 16'hA0 + 16'(i);
      exp_mem[i] = in_data;
      #1;
      vectors++; if ({mem_wen, mem_waddr} !== {1'b1, 8'(i)}) begin miscompares++; $display("FAIL pkt_write%0d: got wen/addr %b/%0d want 1/%0d", i, mem_wen, mem_waddr, i); end
      tick();
    end
    in_wr = 1'b0;
    #1;
    vectors++; if (cpu_sel !== 1'b1) begin miscompares++; $display("FAIL pkt_cpu_sel: got %b want 1", cpu_sel); end
    vectors++; if (pkt_last !== 8'd3) begin miscompares++; $display("FAIL pkt_last: got %0d want 3", pkt_last); end
    vectors++; if (in_rdy !== 1'b0) begin miscompares++; $display("FAIL pkt_in_rdy: got %b want 0", in_rdy); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (mem[i] !== exp_mem[i]) begin miscompares++; $display("FAIL pkt_mem%0d: got %h want %h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_cpu_access;
    cpu_wen = 1'b1; cpu_addr = 8'd2; cpu_data = 16'hC2;
    in_wr = 1'b1; in_ctrl = 8'h00; in_data = 16'hDD;
    exp_mem[2] = 16'hC2;
    #1;
    vectors++; if ({mem_wen, mem_waddr} !== {1'b1, 8'd2}) begin miscompares++; $display("FAIL cpu_write: got wen/addr %b/%0d want 1/2", mem_wen, mem_waddr); end
    tick();
    cpu_wen = 1'b0;
    #1;
    vectors++; if (mem_wen !== 1'b0) begin miscompares++; $display("FAIL proc_net_blocked: got wen %b want 0", mem_wen); end
    vectors++; if (mem[2] !== 16'hC2) begin miscompares++; $display("FAIL cpu_mem2: got %h want c2", mem[2]); end
    vectors++; if (mem[3] !== 16'hA3) begin miscompares++; $display("FAIL cpu_mem3: got %h want a3", mem[3]); end
    in_wr = 1'b0;
  endtask

  task automatic test_send;
    int got = 0;
    int first = -1;
    int last = -1;
    int cyc = 0;
    logic [15:0] w;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_mem[i]);
    out_rdy = 1'b1; cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    vectors++; if (cpu_sel !== 1'b0) begin miscompares++; $display("FAIL send_cpu_sel: got %b want 0", cpu_sel); end
    while (got < 4 && cyc < 20) begin
      tick();
      cyc++;
      if (out_wr) begin
        w = exp_q.pop_front();
        vectors++; if (rd_data !== w) begin miscompares++; $display("FAIL send_word%0d: got %h want %h", got, rd_data, w); end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    vectors++; if (got !== 4) begin miscompares++; $display("FAIL send_count: got %0d want 4", got); end
    vectors++; if (last - first !== 3) begin miscompares++; $display("FAIL send_consecutive: got span %0d want 3", last - first); end
    exp_q.delete();
    tick();
    vectors++; if ({in_rdy, out_wr} !== 2'b10) begin miscompares++; $display("FAIL send_to_idle: got rdy/wr %b want 10", {in_rdy, out_wr}); end
  endtask

  task automatic test_backpressure;
    logic [7:0] ctrls [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    int got = 0;
    int cyc = 0;
    int extra = 0;
    int drop_left = 0;
    bit dropped = 1'b0;
    bit ow;
    logic [15:0] w;
    for (int i = 0; i < 6; i++) begin
      in_wr = 1'b1; in_ctrl = ctrls[i]; in_data = 16'hB0 + 16'(i);
      exp_mem[i] = in_data;
      tick();
    end
    in_wr = 1'b0;
    #1;
    vectors++; if ({cpu_sel, pkt_last} !== {1'b1, 8'd5}) begin miscompares++; $display("FAIL bp_pkt_last: got sel/last %b/%0d want 1/5", cpu_sel, pkt_last); end
    for (int i = 0; i < 6; i++) exp_q.push_back(exp_mem[i]);
    out_rdy = 1'b1; cpu_done = 1'b1; in_wr = 1'b1; in_ctrl = 8'h00;
    #1;
    vectors++; if ({in_rdy, mem_wen} !== 2'b00) begin miscompares++; $display("FAIL proc_to_send_in_wr: got rdy/wen %b want 00", {in_rdy, mem_wen}); end
    tick();
    cpu_done = 1'b0; in_wr = 1'b0;
    while (got < 6 && cyc < 40) begin
      tick();
      cyc++;
      ow = out_wr;
      if (ow) begin
        w = exp_q.pop_front();
        vectors++; if (rd_data !== w) begin miscompares++; $display("FAIL bp_word%0d: got %h want %h", got, rd_data, w); end
        got++;
      end
      if (drop_left > 0) begin
        if (ow) extra++;
        drop_left--;
        if (drop_left == 0) out_rdy = 1'b1;
      end else if (got == 2 && !dropped) begin
        out_rdy = 1'b0; dropped = 1'b1; drop_left = 3;
      end
    end
    vectors++; if (got !== 6) begin miscompares++; $display("FAIL bp_count: got %0d want 6", got); end
    vectors++; if (extra > 1) begin miscompares++; $display("FAIL bp_extra: got %0d want <=1", extra); end
    exp_q.delete();
    tick();
    vectors++; if (in_rdy !== 1'b1) begin miscompares++; $display("FAIL bp_to_idle: got %b want 1", in_rdy); end
  endtask

  task automatic test_overflow;
    int acc = 0;
    in_ctrl = 8'h00; in_wr4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_wen4) begin
        vectors++; if (mem_waddr4 !== 4'(acc)) begin miscompares++; $display("FAIL ovf_addr%0d: got %0d want %0d", acc, mem_waddr4, acc); end
        acc++;
      end
      tick();
    end
    in_wr4 = 1'b0;
    #1;
    vectors++; if (acc !== 16) begin miscompares++; $display("FAIL ovf_stored: got %0d want 16", acc); end
    vectors++; if ({in_rdy4, ovf4, cpu_sel4} !== 3'b011) begin miscompares++; $display("FAIL ovf_flags: got rdy/ovf/sel %b want 011", {in_rdy4, ovf4, cpu_sel4}); end
    vectors++; if (pkt_last4 !== 4'd15) begin miscompares++; $display("FAIL ovf_pkt_last: got %0d want 15", pkt_last4); end
    vectors++; if ({out_wr4, mem_raddr4} !== 5'd0) begin miscompares++; $display("FAIL ovf_idle_read: got wr/raddr %b/%0d want 0/0", out_wr4, mem_raddr4); end
    vectors++; if (ovf_err !== 1'b0) begin miscompares++; $display("FAIL main_no_ovf: got %b want 0", ovf_err); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] ctrls [3] = '{8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 2; i++) begin
      in_wr = 1'b1; in_ctrl = ctrls[i]; in_data = 16'hD0 + 16'(i);
      tick();
    end
    in_wr = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++; if ({cpu_sel, out_wr, in_rdy} !== 3'b001) begin miscompares++; $display("FAIL mid_reset: got sel/wr/rdy %b want 001", {cpu_sel, out_wr, in_rdy}); end
    vectors++; if (ovf4 !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ovf4: got %b want 0", ovf4); end
    for (int i = 0; i < 3; i++) begin
      in_wr = 1'b1; in_ctrl = ctrls[i]; in_data = 16'hE0 + 16'(i);
      #1;
      vectors++; if ({mem_wen, mem_waddr} !== {1'b1, 8'(i)}) begin miscompares++; $display("FAIL mid_write%0d: got wen/addr %b/%0d want 1/%0d", i, mem_wen, mem_waddr, i); end
      tick();
    end
    in_wr = 1'b0;
    #1;
    vectors++; if ({cpu_sel, pkt_last} !== {1'b1, 8'd2}) begin miscompares++; $display("FAIL mid_pkt_last: got sel/last %b/%0d want 1/2", cpu_sel, pkt_last); end
  endtask

  initial begin
    reset = 1'b1; in_wr = 1'b0; in_wr4 = 1'b0; in_ctrl = '0; out_rdy = 1'b0;
    cpu_done = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; in_data = '0; cpu_data = '0;
    test_reset();
    test_packet();
    test_cpu_access();
    test_send();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pkt_buf_ctrl.md
# pkt_buf_ctrl

Controller for the single-packet CPU FIFO buffer: a dual-port packet memory shared between the network pipeline and the soft CPU. It gates network writes into the memory, hands the buffer to the CPU once a full packet is stored, and drains the packet downstream after the CPU signals completion. It sits between the upstream NetFPGA module-header interface and the packet memory, and muxes memory write and address ownership between the network side and the CPU side.

## Interface
- ADDR_WIDTH, 8: packet memory address width; depth = 2^ADDR_WIDTH words.
- CTRL_WIDTH, 8: width of the NetFPGA ctrl field.

- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- in_wr  in  1  upstream word valid.
- in_ctrl  in  CTRL_WIDTH  upstream ctrl field of the current word.
- in_rdy  out  1  buffer accepts words; combinational from state and wptr.
- out_rdy  in  1  downstream can accept a word.
- out_wr  out  1  registered; memory read data is valid downstream this cycle.
- cpu_done  in  1  single-cycle pulse: CPU finished processing.
- cpu_wen  in  1  CPU write enable.
- cpu_addr  in  ADDR_WIDTH  CPU memory address.
- mem_wen  out  1  write enable to packet memory port A.
- mem_waddr  out  ADDR_WIDTH  port A address: wptr on the network side, cpu_addr on the CPU side.
- mem_raddr  out  ADDR_WIDTH  port B read address: rptr in SEND, cpu_addr otherwise.
- cpu_sel  out  1  registered; 1 means the CPU owns the memory.
- pkt_last  out  ADDR_WIDTH  registered address of the last stored word.
- ovf_err  out  1  sticky; the packet did not fit in the buffer.

## Operation
- The controller has four states: IDLE, RECV, PROC and SEND.
- Network write enable: net_wen = in_wr & in_rdy & (state is IDLE or RECV).
- Memory write mux: mem_wen = cpu_sel ? cpu_wen : net_wen.
- in_rdy = (state is IDLE or RECV) & ~full. full is set once the word at address 2^ADDR_WIDTH−1 is written.
- End of packet (EOP) is the first word with in_ctrl != 0 that follows at least one word with in_ctrl == 0, counted from the start of the packet.
- IDLE:
  - wptr = 0.
  - On net_wen, write the word and go to RECV.
- RECV:
  - Each net_wen writes at wptr, then wptr increments.
  - On an EOP write, latch pkt_last = wptr and go to PROC.
  - If the word at the top address is written without EOP, set ovf_err, set pkt_last to the top address and go to PROC.
- PROC:
  - cpu_sel = 1 and in_rdy = 0.
  - On cpu_done, go to SEND with rptr = 0.
  - cpu_done in any other state is ignored.
- SEND:
  - cpu_sel = 0.
  - In each cycle with out_rdy = 1 and rptr ≤ pkt_last, issue a read at rptr and increment rptr.
  - out_wr is asserted the following cycle.
  - After the read at pkt_last has been issued and its out_wr has been emitted, go to IDLE. ovf_err stays set.
- Pointer arithmetic is ADDR_WIDTH unsigned. wptr never wraps because full blocks writes.
- ovf_err clears only on reset.
- Reset mid-operation: on the next edge, every state returns to IDLE and the in-flight packet is discarded.

## Timing
- Reset values:
  - state = IDLE.
  - wptr, rptr, pkt_last = 0.
  - out_wr = 0, cpu_sel = 0, ovf_err = 0.
  - in_rdy = 1 once reset deasserts.
- Write latency: a word offered with in_wr is in memory at the next edge.
- Read latency: 1 cycle from raddr issue to out_wr.
- Downstream must absorb one word after it deasserts out_rdy.
- cpu_sel rises 1 cycle after the EOP write and falls 1 cycle after cpu_done.
- A packet of N words takes N + 1 cycles from the first SEND cycle to the last out_wr when out_rdy is held high.
- If in_wr arrives in the same cycle as the PROC→SEND transition, it is not accepted (in_rdy = 0).

## Structure
- State encodings and the EOP/ctrl constants go in the shared header pkt_buf_defs.vh.
- The read pointer, issue logic and out_wr pipeline register form the natural sub-module pkt_buf_rd_pipe.
- The FSM, write pointer and muxes stay at the top level.

## Test plan
- Reset, then a 4-word packet with ctrl 0xFF, 0, 0, 0x01 → words written at addresses 0–3, pkt_last = 3, cpu_sel = 1 one cycle after the 4th write, in_rdy = 0.
- In PROC, cpu_wen = 1 with cpu_addr = 2 and new data → mem_wen = 1 with mem_waddr = 2. Concurrent in_wr → mem_wen from the network side stays 0.
- cpu_done pulse with out_rdy held at 1 → out_wr high for 4 consecutive cycles carrying words 0–3, then state returns to IDLE and in_rdy = 1.
- During SEND, drop out_rdy for 3 cycles after 2 words → at most 1 extra out_wr; the remaining words follow once out_rdy returns; no word is skipped or repeated.
- ADDR_WIDTH = 4 with a 20-word packet lacking EOP → 16 words stored, in_rdy = 0, ovf_err = 1, pkt_last = 15, FSM enters PROC.
- Assert reset during RECV after 2 words → next cycle state is IDLE, wptr = 0, cpu_sel = 0, out_wr = 0. A following packet is stored starting at address 0.
